// File: rtl/fifo_pkg.sv
// Shared constants for the fifo_ctrl slice: output-stage state encodings
// and the depth / pointer-width helpers used by the controller and memory.
package fifo_pkg;

    localparam logic OUT_EMPTY = 1'b0;
    localparam logic OUT_VALID = 1'b1;

    localparam int DEFAULT_ADDR_SIZE = 4;
    localparam int DEFAULT_DATA_SIZE = 4;

    function automatic int fifo_depth(input int addr_size);
        return 1 << addr_size;
    endfunction

    // One extra bit beyond the address distinguishes full from empty.
    function automatic int ptr_width(input int addr_size);
        return addr_size + 1;
    endfunction

endpackage

// File: rtl/fifomem.sv
// Storage array for fifo_ctrl: synchronous write, asynchronous read so the
// controller can register the head word straight into its output stage.
module fifomem
    import fifo_pkg::*;
#(
    parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
    parameter int ADDR_SIZE = DEFAULT_ADDR_SIZE
) (
    input  logic                 wr_clk,
    input  logic                 rd_clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [ADDR_SIZE-1:0] wr_addr,
    input  logic [DATA_SIZE-1:0] wr_data,
    input  logic [ADDR_SIZE-1:0] rd_addr,
    output logic [DATA_SIZE-1:0] rd_data
);

    localparam int DEPTH = fifo_depth(ADDR_SIZE);

    logic [DATA_SIZE-1:0] mem [DEPTH];

    // Read side is combinational; the read clock exists for interface symmetry.
    logic unused_rd_clk;
    assign unused_rd_clk = rd_clk;

    always_ff @(posedge wr_clk) begin
        if (wr_en && !rst) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller: wrap-bit pointers over fifomem plus a one-entry registered
// output stage, giving DEPTH+1 words of capacity and flags from state only.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
    parameter int ADDR_SIZE = DEFAULT_ADDR_SIZE,
    parameter int AFULL_TH  = fifo_depth(ADDR_SIZE) - 1,
    parameter int AEMPTY_TH = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 push_valid,
    output logic                 push_ready,
    input  logic [DATA_SIZE-1:0] push_data,
    output logic                 pop_valid,
    input  logic                 pop_ready,
    output logic [DATA_SIZE-1:0] pop_data,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADDR_SIZE:0]   count
);

    localparam int PTR_W = ptr_width(ADDR_SIZE);
    localparam int DEPTH = fifo_depth(ADDR_SIZE);
    localparam logic [PTR_W-1:0] DEPTH_V   = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] AFULL_V   = PTR_W'(AFULL_TH);
    localparam logic [PTR_W-1:0] AEMPTY_V  = PTR_W'(AEMPTY_TH);

    logic [PTR_W-1:0]     wptr_q, wptr_d, rptr_q, rptr_d, mem_count;
    logic                 state_q, state_d;
    logic [DATA_SIZE-1:0] pop_data_q, pop_data_d, rd_data;
    logic                 mem_full, mem_empty, push_fire, load;

    assign mem_count = wptr_q - rptr_q;
    assign mem_full  = (mem_count == DEPTH_V);
    assign mem_empty = (wptr_q == rptr_q);

    assign push_ready = !mem_full && !flush;
    assign push_fire  = push_valid && push_ready;
    // Stage refills whenever it is empty or its word leaves this cycle.
    assign load       = !mem_empty && ((state_q == OUT_EMPTY) || pop_ready);

    always_comb begin
        wptr_d     = wptr_q + PTR_W'(push_fire);
        rptr_d     = rptr_q + PTR_W'(load);
        state_d    = state_q;
        pop_data_d = pop_data_q;
        if (load) begin
            state_d    = OUT_VALID;
            pop_data_d = rd_data;
        end else if (pop_ready) begin
            state_d = OUT_EMPTY;
        end
        if (flush) begin
            wptr_d     = '0;
            rptr_d     = '0;
            state_d    = OUT_EMPTY;
            pop_data_d = pop_data_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            state_q    <= OUT_EMPTY;
            pop_data_q <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            state_q    <= state_d;
            pop_data_q <= pop_data_d;
        end
    end

    assign pop_valid    = (state_q == OUT_VALID);
    assign pop_data     = pop_data_q;
    assign count        = mem_count + PTR_W'(pop_valid);
    assign full         = mem_full;
    assign empty        = (count == '0);
    assign almost_full  = (count >= AFULL_V);
    assign almost_empty = (count <= AEMPTY_V);

    fifomem #(
        .DATA_SIZE(DATA_SIZE),
        .ADDR_SIZE(ADDR_SIZE)
    ) u_mem (
        .wr_clk  (clk),
        .rd_clk  (clk),
        .rst     (!rst_n),
        .wr_en   (push_fire),
        .wr_addr (wptr_q[ADDR_SIZE-1:0]),
        .wr_data (push_data),
        .rd_addr (rptr_q[ADDR_SIZE-1:0]),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: directed scenarios plus random traffic, all outputs
// compared each cycle against a queue-based behavioural model.
module tb_fifo_ctrl;

    localparam int DW = 4;
    localparam int AW = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n, flush, push_valid, push_ready, pop_valid, pop_ready;
    logic [DW-1:0] push_data, pop_data;
    logic          full, empty, almost_full, almost_empty;
    logic [AW:0]   count;

    int nvec = 0;
    int nerr = 0;

    // Model: words waiting in memory, plus the visible head word.
    int mq[$];
    bit m_ov;
    int m_od;
    bit got_pop;
    int got_data;

    always #5 clk = ~clk;

    fifo_ctrl #(
        .DATA_SIZE(DW), .ADDR_SIZE(AW), .AFULL_TH(4), .AEMPTY_TH(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
        .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
        .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_model();
        int c;
        c = mq.size() + int'(m_ov);
        chk("count", 32'(count), 32'(c));
        chk("pop_valid", 32'(pop_valid), 32'(m_ov));
        if (m_ov) chk("pop_data", 32'(pop_data), 32'(m_od));
        chk("full", 32'(full), 32'(mq.size() == DEPTH));
        chk("empty", 32'(empty), 32'(c == 0));
        chk("almost_full", 32'(almost_full), 32'(c >= 4));
        chk("almost_empty", 32'(almost_empty), 32'(c <= 1));
        chk("push_ready", 32'(push_ready), 32'(mq.size() < DEPTH && !flush));
    endtask

    task automatic step(input bit pv, input int pd, input bit pr, input bit fl);
        bit push_acc, pop_acc;
        push_valid = pv; push_data = DW'(pd); pop_ready = pr; flush = fl;
        push_acc = pv && !fl && (mq.size() < DEPTH);
        pop_acc  = m_ov && pr;
        got_pop  = pop_acc && !fl;
        got_data = m_od;
        @(posedge clk);
        if (fl) begin
            mq.delete();
            m_ov = 0;
        end else begin
            if (!m_ov || pop_acc) begin
                if (mq.size() > 0) begin
                    m_od = mq.pop_front();
                    m_ov = 1;
                end else begin
                    m_ov = 0;
                end
            end
            if (push_acc) mq.push_back(pd & 'hF);
        end
        #1;
        check_model();
    endtask

    task automatic idle();
        step(0, 0, 0, 0);
    endtask

    initial begin
        int exp_q[$];
        int rcv[$];
        rst_n = 0; flush = 0; push_valid = 0; pop_ready = 0; push_data = '0;
        mq.delete(); m_ov = 0; m_od = 0;
        #12;
        check_model();
        chk("rst_pop_data", 32'(pop_data), 0);
        @(negedge clk);
        rst_n = 1;

        // Single push then drain
        step(1, 'hA, 0, 0);
        chk("single_cnt1", 32'(count), 1);
        chk("single_nv", 32'(pop_valid), 0);
        idle();
        chk("single_pv", 32'(pop_valid), 1);
        chk("single_data", 32'(pop_data), 'hA);
        step(0, 0, 1, 0);
        chk("single_empty", 32'(empty), 1);
        chk("single_cnt0", 32'(count), 0);

        // Fill to full, refused sixth push, ordered drain
        for (int i = 1; i <= 5; i++) step(1, i, 0, 0);
        chk("fill_cnt", 32'(count), 5);
        chk("fill_full", 32'(full), 1);
        chk("fill_prdy", 32'(push_ready), 0);
        step(1, 6, 0, 0);
        chk("fill_cnt6", 32'(count), 5);
        for (int i = 1; i <= 5; i++) begin
            chk("drain_data", 32'(pop_data), 32'(i));
            step(0, 0, 1, 0);
        end
        chk("drain_empty", 32'(empty), 1);

        // Wrap-around streaming
        for (int i = 0; i < 20; i++) exp_q.push_back(i % 16);
        for (int i = 0; i < 20; i++) begin
            step(1, i % 16, 1, 0);
            if (got_pop) rcv.push_back(32'(got_data));
            chk("stream_le2", 32'(count <= 2), 1);
        end
        for (int i = 0; i < 8 && rcv.size() < 20; i++) begin
            step(0, 0, 1, 0);
            if (got_pop) rcv.push_back(32'(got_data));
        end
        chk("stream_n", 32'(rcv.size()), 20);
        for (int i = 0; i < 20 && i < rcv.size(); i++) chk("stream_word", 32'(rcv[i]), 32'(exp_q[i]));
        step(0, 0, 0, 0);

        // Simultaneous push and pop while full
        for (int i = 0; i < 5; i++) step(1, 8 + i, 0, 0);
        chk("sim_cnt5", 32'(count), 5);
        step(1, 'hF, 1, 0);
        chk("sim_cnt4", 32'(count), 4);
        chk("sim_head", 32'(pop_data), 9);

        // Flush with a concurrent push
        step(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 2 + i, 0, 0);
        chk("fl_cnt3", 32'(count), 3);
        step(1, 'hE, 0, 1);
        chk("fl_cnt0", 32'(count), 0);
        chk("fl_empty", 32'(empty), 1);
        chk("fl_pv", 32'(pop_valid), 0);
        idle();
        idle();
        chk("fl_stay", 32'(count), 0);

        // Reset mid-stream
        for (int i = 0; i < 4; i++) step(1, 3 + i, 0, 0);
        chk("mr_cnt4", 32'(count), 4);
        push_valid = 0;
        #2;
        rst_n = 0;
        mq.delete(); m_ov = 0; m_od = 0;
        #1;
        check_model();
        chk("mr_data0", 32'(pop_data), 0);
        @(negedge clk);
        rst_n = 1;
        step(1, 7, 0, 0);
        chk("mr_cnt1", 32'(count), 1);
        idle();
        chk("mr_data7", 32'(pop_data), 7);
        step(0, 0, 1, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(bit'($urandom_range(0, 2) != 0), int'($urandom_range(0, 15)),
                 bit'($urandom_range(0, 1)), bit'($urandom_range(0, 31) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
